calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 120 ++++++++++++
 tb/tb_calc_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: Moore sequencer for a calculator front end.
// Steps through operand digit entry, operation entry, result display and a
// one-cycle register clear, emitting load strobes for the external banks.
module calc_sequencer #(
  parameter int N_OPS  = 2,
  parameter int DIGITS = 4,
  parameter int EW     = $clog2(N_OPS + 3)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         exe,
  input  logic                         button,
  input  logic                         clear,
  output logic [N_OPS-1:0]             load,
  output logic                         op_load,
  output logic                         reg_clear,
  output logic [EW-1:0]                estado,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

  localparam int IW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [2:0] S_ENTRY   = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_OP_WAIT = 3'd2;
  localparam logic [2:0] S_OP_LOAD = 3'd3;
  localparam logic [2:0] S_OP_HOLD = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;
  localparam logic [2:0] S_CLEAR   = 3'd6;

  logic [2:0]    state;
  logic [IW-1:0] idx;

  // State, operand index and digit counter; clear overrides everything except an ongoing CLEAR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ENTRY;
      idx       <= '0;
      digit_cnt <= '0;
    end else if (clear && (state != S_CLEAR)) begin
      state <= S_CLEAR;
    end else begin
      case (state)
        S_ENTRY: begin
          if (exe) begin
            if (idx == IW'(N_OPS - 1)) begin
              state <= S_OP_WAIT;
            end else begin
              idx       <= idx + IW'(1);
              digit_cnt <= '0;
            end
          end else if (button && (digit_cnt < CW'(DIGITS))) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          digit_cnt <= digit_cnt + CW'(1);
          state     <= S_ENTRY;
        end
        S_OP_WAIT: begin
          if (button) state <= S_OP_LOAD;
        end
        S_OP_LOAD: begin
          state <= S_OP_HOLD;
        end
        S_OP_HOLD: begin
          if (exe) state <= S_RESULT;
        end
        S_RESULT: begin
          if (exe) state <= S_CLEAR;
        end
        S_CLEAR: begin
          state     <= S_ENTRY;
          idx       <= '0;
          digit_cnt <= '0;
        end
        default: begin
          state     <= S_ENTRY;
          idx       <= '0;
          digit_cnt <= '0;
        end
      endcase
    end
  end

  // Moore output decode from the registered state and operand index only
  always_comb begin
    load      = '0;
    op_load   = 1'b0;
    reg_clear = 1'b0;
    estado    = '0;
    for (int k = 0; k < N_OPS; k++) begin
      load[k] = (state == S_LOAD) && (idx == IW'(k));
    end
    case (state)
      S_ENTRY, S_LOAD: begin
        estado = EW'(idx);
      end
      S_OP_WAIT, S_OP_HOLD: begin
        estado = EW'(N_OPS);
      end
      S_OP_LOAD: begin
        estado  = EW'(N_OPS);
        op_load = 1'b1;
      end
      S_RESULT: begin
        estado = EW'(N_OPS + 1);
      end
      S_CLEAR: begin
        estado    = EW'(N_OPS + 2);
        reg_clear = 1'b1;
      end
      default: begin
        estado = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench for calc_sequencer with a scoreboard queue.
// Instance A uses N_OPS=2/DIGITS=4, instance B uses N_OPS=3/DIGITS=1.
module tb_calc_sequencer;

  logic clk;
  logic rst;
  logic exeA, buttonA, clearA;
  logic exeB, buttonB, clearB;

  logic [1:0] loadA;
  logic       opLoadA, regClearA;
  logic [2:0] estA;
  logic [2:0] cntA;

  logic [2:0] loadB;
  logic       opLoadB, regClearB;
  logic [2:0] estB;
  logic [0:0] cntB;

  typedef struct packed {
    logic [3:0] ld;
    logic       op;
    logic       rc;
    logic [3:0] est;
    logic [3:0] cnt;
  } out_t;

  typedef struct {
    out_t  v;
    logic  cntDc;
    logic  dut;
    string tag;
  } exp_t;

  exp_t expQ[$];
  int   vectors;
  int   miscompares;

  calc_sequencer #(.N_OPS(2), .DIGITS(4)) dutA (
    .clk       (clk),
    .rst       (rst),
    .exe       (exeA),
    .button    (buttonA),
    .clear     (clearA),
    .load      (loadA),
    .op_load   (opLoadA),
    .reg_clear (regClearA),
    .estado    (estA),
    .digit_cnt (cntA)
  );

  calc_sequencer #(.N_OPS(3), .DIGITS(1)) dutB (
    .clk       (clk),
    .rst       (rst),
    .exe       (exeB),
    .button    (buttonB),
    .clear     (clearB),
    .load      (loadB),
    .op_load   (opLoadB),
    .reg_clear (regClearB),
    .estado    (estB),
    .digit_cnt (cntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExp(input logic dut, input logic [3:0] ld, input logic op, input logic rc,
                         input logic [3:0] est, input logic [3:0] cnt, input logic cntDc,
                         input string tag);
    exp_t e;
    e.v.ld  = ld;
    e.v.op  = op;
    e.v.rc  = rc;
    e.v.est = est;
    e.v.cnt = cnt;
    e.cntDc = cntDc;
    e.dut   = dut;
    e.tag   = tag;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    out_t obs;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: observed no entry, expected one queued entry");
    end else begin
      e = expQ.pop_front();
      if (e.dut) begin
        obs.ld  = {1'b0, loadB};
        obs.op  = opLoadB;
        obs.rc  = regClearB;
        obs.est = {1'b0, estB};
        obs.cnt = {3'b000, cntB};
      end else begin
        obs.ld  = {2'b00, loadA};
        obs.op  = opLoadA;
        obs.rc  = regClearA;
        obs.est = {1'b0, estA};
        obs.cnt = {1'b0, cntA};
      end
      if (e.cntDc) obs.cnt = e.v.cnt;
      assert (obs === e.v) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed ld=%b op=%b rc=%b est=%0d cnt=%0d, expected ld=%b op=%b rc=%b est=%0d cnt=%0d",
               e.tag, obs.ld, obs.op, obs.rc, obs.est, obs.cnt,
               e.v.ld, e.v.op, e.v.rc, e.v.est, e.v.cnt);
      end
    end
  endtask

  // Drive one cycle of inputs on the chosen instance, queue the expected Moore outputs, check after the edge
  task automatic applyStimulus(input logic dut, input logic e, input logic b, input logic c,
                               input logic [3:0] ld, input logic op, input logic rc,
                               input logic [3:0] est, input logic [3:0] cnt, input logic cntDc,
                               input string tag);
    exeA    = dut ? 1'b0 : e;
    buttonA = dut ? 1'b0 : b;
    clearA  = dut ? 1'b0 : c;
    exeB    = dut ? e : 1'b0;
    buttonB = dut ? b : 1'b0;
    clearB  = dut ? c : 1'b0;
    pushExp(dut, ld, op, rc, est, cnt, cntDc, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkReset(input string tag);
    pushExp(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, tag);
    checkOutput();
    pushExp(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, tag);
    checkOutput();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b0;
    exeA    = 1'b0; buttonA = 1'b0; clearA = 1'b0;
    exeB    = 1'b0; buttonB = 1'b0; clearB = 1'b0;

    #2;
    checkReset("reset_async");
    @(posedge clk);
    #1;
    checkReset("reset_held_over_edge");
    #2;
    rst = 1'b1;

    // Five digits into operand 0: four loads, fifth ignored
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 4'b0001, 0, 0, 4'd0, 4'(i), 0, "fill_load");
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'(i + 1), 0, "fill_cnt");
    end
    applyStimulus(0, 0, 1, 0, 4'b0000, 0, 0, 4'd0, 4'd4, 0, "fifth_button_ignored");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd4, 0, "fifth_button_cnt");
    applyStimulus(0, 0, 0, 1, 4'b0000, 0, 1, 4'd4, 4'd0, 1, "clear_after_fill");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd0, 0, "entry_after_clear");

    // Full calculation walk: 2 digits, exe, 1 digit, exe, op, exe, exe
    applyStimulus(0, 0, 1, 0, 4'b0001, 0, 0, 4'd0, 4'd0, 0, "walk_d0_load");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd1, 0, "walk_d0_cnt");
    applyStimulus(0, 0, 1, 0, 4'b0001, 0, 0, 4'd0, 4'd1, 0, "walk_d1_load");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd2, 0, "walk_d1_cnt");
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0, 4'd1, 4'd0, 0, "walk_next_operand");
    applyStimulus(0, 0, 1, 0, 4'b0010, 0, 0, 4'd1, 4'd0, 0, "walk_op1_load");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd1, 4'd1, 0, "walk_op1_cnt");
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0, 4'd2, 4'd0, 1, "walk_op_wait");
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0, 4'd2, 4'd0, 1, "walk_op_wait_exe_ignored");
    applyStimulus(0, 0, 1, 0, 4'b0000, 1, 0, 4'd2, 4'd0, 1, "walk_op_load");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd2, 4'd0, 1, "walk_op_hold");
    applyStimulus(0, 0, 1, 0, 4'b0000, 0, 0, 4'd2, 4'd0, 1, "walk_hold_button_ignored");
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0, 4'd3, 4'd0, 1, "walk_result");
    applyStimulus(0, 0, 1, 0, 4'b0000, 0, 0, 4'd3, 4'd0, 1, "walk_result_button_ignored");
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 1, 4'd4, 4'd0, 1, "walk_clear");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd0, 0, "walk_back_to_entry");

    // exe and button together: exe wins, no load
    applyStimulus(0, 1, 1, 0, 4'b0000, 0, 0, 4'd1, 4'd0, 0, "exe_beats_button");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd1, 4'd0, 0, "exe_beats_button_settle");
    applyStimulus(0, 0, 0, 1, 4'b0000, 0, 1, 4'd4, 4'd0, 1, "abort_1");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd0, 0, "abort_1_entry");

    // Abort in operand 1 with two digits entered
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0, 4'd1, 4'd0, 0, "abort2_to_op1");
    applyStimulus(0, 0, 1, 0, 4'b0010, 0, 0, 4'd1, 4'd0, 0, "abort2_load_a");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd1, 4'd1, 0, "abort2_cnt_a");
    applyStimulus(0, 0, 1, 0, 4'b0010, 0, 0, 4'd1, 4'd1, 0, "abort2_load_b");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd1, 4'd2, 0, "abort2_cnt_b");
    applyStimulus(0, 0, 0, 1, 4'b0000, 0, 1, 4'd4, 4'd0, 1, "abort2_clear");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd0, 0, "abort2_entry");
    applyStimulus(0, 1, 1, 1, 4'b0000, 0, 1, 4'd4, 4'd0, 1, "clear_overrides_all");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd0, 0, "clear_overrides_entry");

    // Reset dropped in the middle of a LOAD cycle
    applyStimulus(0, 0, 1, 0, 4'b0001, 0, 0, 4'd0, 4'd0, 0, "rst_mid_load_pre");
    exeA = 1'b0; buttonA = 1'b0; clearA = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checkReset("rst_mid_load_async");
    #1;
    rst = 1'b1;
    applyStimulus(0, 0, 1, 0, 4'b0001, 0, 0, 4'd0, 4'd0, 0, "post_rst_first_edge");
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd1, 0, "post_rst_cnt");

    // Instance B: three single-digit operands, extra buttons ignored
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 1, 0, 4'(1 << k), 0, 0, 4'(k), 4'd0, 0, "b_digit_load");
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0, 4'(k), 4'd1, 0, "b_digit_cnt");
      applyStimulus(1, 0, 1, 0, 4'b0000, 0, 0, 4'(k), 4'd1, 0, "b_second_button_ignored");
      if (k < 2) begin
        applyStimulus(1, 1, 0, 0, 4'b0000, 0, 0, 4'(k + 1), 4'd0, 0, "b_next_operand");
      end
    end
    applyStimulus(1, 1, 0, 0, 4'b0000, 0, 0, 4'd3, 4'd0, 1, "b_op_wait");
    applyStimulus(1, 0, 1, 0, 4'b0000, 1, 0, 4'd3, 4'd0, 1, "b_op_load");
    applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0, 4'd3, 4'd0, 1, "b_op_hold");
    applyStimulus(1, 1, 0, 0, 4'b0000, 0, 0, 4'd4, 4'd0, 1, "b_result");
    applyStimulus(1, 1, 0, 0, 4'b0000, 0, 1, 4'd5, 4'd0, 1, "b_clear");
    applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0, 4'd0, 4'd0, 0, "b_back_to_entry");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
